// File: rtl/dm_arbiter_if.sv
// Bundles the CPU port, debug port and data-memory signals of dm_arbiter.
// slave: the arbiter's view. master: requesters plus the memory model.
interface dm_arbiter_if #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
);
    logic              c_req;
    logic              c_we;
    logic [31:0]       c_addr;
    logic [DATA_W-1:0] c_wdata;
    logic [31:0]       c_pc;
    logic [DATA_W-1:0] c_rdata;
    logic              c_ack;
    logic              c_stall;

    logic              d_req;
    logic              d_we;
    logic [31:0]       d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic [DATA_W-1:0] d_rdata;
    logic              d_ack;

    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              err;

    modport slave (
        input  c_req, c_we, c_addr, c_wdata, c_pc,
        output c_rdata, c_ack, c_stall,
        input  d_req, d_we, d_addr, d_wdata,
        output d_rdata, d_ack,
        output mem_we, mem_addr, mem_wdata, err,
        input  mem_rdata
    );

    modport master (
        output c_req, c_we, c_addr, c_wdata, c_pc,
        input  c_rdata, c_ack, c_stall,
        output d_req, d_we, d_addr, d_wdata,
        input  d_rdata, d_ack,
        input  mem_we, mem_addr, mem_wdata, err,
        output mem_rdata
    );
endinterface

// File: rtl/dm_arbiter.sv
// Round-robin CPU/debug access controller for the single-port data memory; ack 2 cycles after req, one access per 3 cycles.
// Loser's req stays pending and is served next; c_stall holds the pipeline until c_ack. Optional DM_TRACE_EN prints committed writes.
module dm_arbiter #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
) (
    input  logic        clk,
    input  logic        Reset,
    dm_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
    localparam logic PORT_C = 1'b0;
    localparam logic PORT_D = 1'b1;

    state_t            state, state_nxt;
    logic              gnt;
    logic              last_gnt;
    logic              lat_we;
    logic              lat_port;
    logic [31:0]       lat_addr;
    logic [DATA_W-1:0] lat_wdata;
    logic [DATA_W-1:0] c_rdata_q;
    logic [DATA_W-1:0] d_rdata_q;
    logic              valid;
    logic              start;

    // Word aligned and inside the 2^ADDR_W word window.
    assign valid = (lat_addr[1:0] == 2'b00) && (lat_addr[31:ADDR_W+2] == '0);
    assign start = (state == IDLE) && (bus.c_req || bus.d_req);

    always_comb begin
        gnt = (bus.c_req && bus.d_req) ? ~last_gnt : bus.d_req;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.c_req || bus.d_req) state_nxt = ACCESS;
            ACCESS:  state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            last_gnt  <= PORT_D;
            lat_we    <= 1'b0;
            lat_port  <= PORT_C;
            lat_addr  <= '0;
            lat_wdata <= '0;
            c_rdata_q <= '0;
            d_rdata_q <= '0;
        end else begin
            if (start) begin
                last_gnt  <= gnt;
                lat_port  <= gnt;
                lat_we    <= gnt ? bus.d_we    : bus.c_we;
                lat_addr  <= gnt ? bus.d_addr  : bus.c_addr;
                lat_wdata <= gnt ? bus.d_wdata : bus.c_wdata;
            end
            // Reads land on the edge leaving ACCESS; an invalid address reads as zero.
            if (state == ACCESS && !lat_we) begin
                if (lat_port == PORT_D) d_rdata_q <= valid ? bus.mem_rdata : '0;
                else                    c_rdata_q <= valid ? bus.mem_rdata : '0;
            end
        end
    end

    assign bus.mem_we    = (state == ACCESS) && lat_we && valid;
    assign bus.mem_addr  = lat_addr[ADDR_W+1:2];
    assign bus.mem_wdata = lat_wdata;
    assign bus.c_ack     = (state == DONE) && (lat_port == PORT_C);
    assign bus.d_ack     = (state == DONE) && (lat_port == PORT_D);
    assign bus.err       = (state == DONE) && !valid;
    assign bus.c_rdata   = c_rdata_q;
    assign bus.d_rdata   = d_rdata_q;
    assign bus.c_stall   = bus.c_req && !bus.c_ack;

`ifdef DM_TRACE_EN
    logic [31:0] lat_pc;

    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset)     lat_pc <= '0;
        else if (start) lat_pc <= gnt ? 32'hFFFF_FFFF : bus.c_pc;
    end

    always_ff @(posedge clk) begin
        if (bus.mem_we) $display("@%h: *%h <= %h", lat_pc, lat_addr, lat_wdata);
    end
`else
    logic unused_pc;
    assign unused_pc = ^bus.c_pc;
`endif
endmodule

// File: tb/tb_dm_arbiter.sv
// Self-checking bench for dm_arbiter: scoreboard of predicted acks/rdata/err against a reference memory,
// plus a behavioural memory driven by the DUT's mem_* port.
module tb_dm_arbiter;
    localparam int ADDR_W = 10;
    localparam int DATA_W = 32;

    typedef struct {
        bit          port;
        logic [31:0] rdata;
        bit          err;
    } exp_t;

    logic clk = 1'b0;
    logic Reset;
    always #5 clk = ~clk;

    dm_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();
    dm_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (.clk(clk), .Reset(Reset), .bus(bus));

    logic [31:0] mem [0:1023];
    assign bus.mem_rdata = mem[bus.mem_addr];
    always @(posedge clk) if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;

    int          n_cmp = 0;
    int          n_bad = 0;
    exp_t        sb[$];
    logic [31:0] ref_mem [int];
    logic [31:0] exp_c_rd;
    logic [31:0] exp_d_rd;

    function automatic exp_t predict(bit port, bit we, logic [31:0] addr, logic [31:0] wdata);
        exp_t        e;
        bit          ok;
        logic [31:0] v;
        ok = (addr % 4 == 0) && (addr < 32'h0000_1000);
        e.port = port;
        e.err  = !ok;
        if (we) begin
            if (ok) ref_mem[int'(addr >> 2)] = wdata;
        end else begin
            v = ok ? ref_mem[int'(addr >> 2)] : 32'h0;
            if (port) exp_d_rd = v;
            else      exp_c_rd = v;
        end
        e.rdata = port ? exp_d_rd : exp_c_rd;
        return e;
    endfunction

    // Single request on one port; returns ack latency in negedges (-1 on timeout), stall and mem_we counts.
    task automatic drive(input bit port, input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] pc, output int lat, output int stalls, output int wes,
                         output logic [31:0] rdata, output logic e);
        lat = -1; stalls = 0; wes = 0; rdata = '0; e = 1'b0;
        if (port) begin
            bus.d_we = we; bus.d_addr = addr; bus.d_wdata = wdata; bus.d_req = 1'b1;
        end else begin
            bus.c_we = we; bus.c_addr = addr; bus.c_wdata = wdata; bus.c_pc = pc; bus.c_req = 1'b1;
        end
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (bus.c_stall) stalls++;
            if (bus.mem_we) wes++;
            if (port ? bus.d_ack : bus.c_ack) begin
                lat   = k;
                rdata = port ? bus.d_rdata : bus.c_rdata;
                e     = bus.err;
                break;
            end
        end
        bus.c_req = 1'b0;
        bus.d_req = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        Reset = 1'b0;
        bus.c_req = 0; bus.c_we = 0; bus.c_addr = 0; bus.c_wdata = 0; bus.c_pc = 0;
        bus.d_req = 0; bus.d_we = 0; bus.d_addr = 0; bus.d_wdata = 0;
        exp_c_rd = '0; exp_d_rd = '0;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++; if ({bus.c_ack, bus.d_ack, bus.err, bus.mem_we, bus.c_stall} !== 5'b0) begin
            n_bad++; $display("FAIL reset_ctrl: got %b want 00000", {bus.c_ack, bus.d_ack, bus.err, bus.mem_we, bus.c_stall});
        end
        n_cmp++; if ({bus.c_rdata, bus.d_rdata, 22'(bus.mem_addr)} !== 86'h0) begin
            n_bad++; $display("FAIL reset_data: c_rdata %h d_rdata %h mem_addr %h want all 0", bus.c_rdata, bus.d_rdata, bus.mem_addr);
        end
        @(negedge clk); Reset = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_cpu_write();
        exp_t ex; int lat, st, wes; logic [31:0] rd; logic e;
        sb.push_back(predict(1'b0, 1'b1, 32'h10, 32'h1234_5678));
        drive(1'b0, 1'b1, 32'h10, 32'h1234_5678, 32'h100, lat, st, wes, rd, e);
        ex = sb.pop_front();
        n_cmp++; if (lat !== 3) begin n_bad++; $display("FAIL wr_latency: got %0d want 3", lat); end
        n_cmp++; if (st !== 2) begin n_bad++; $display("FAIL wr_stall_cycles: got %0d want 2", st); end
        n_cmp++; if (wes !== 1) begin n_bad++; $display("FAIL wr_mem_we_cycles: got %0d want 1", wes); end
        n_cmp++; if (e !== ex.err) begin n_bad++; $display("FAIL wr_err: got %b want %b", e, ex.err); end
        n_cmp++; if (mem[4] !== 32'h1234_5678) begin n_bad++; $display("FAIL wr_word4: got %h want 12345678", mem[4]); end
        n_cmp++; if (rd !== ex.rdata) begin n_bad++; $display("FAIL wr_rdata_unchanged: got %h want %h", rd, ex.rdata); end
    endtask

    task automatic test_cpu_read();
        exp_t ex; int lat, st, wes; logic [31:0] rd; logic e;
        sb.push_back(predict(1'b0, 1'b0, 32'h10, 32'h0));
        drive(1'b0, 1'b0, 32'h10, 32'h0, 32'h104, lat, st, wes, rd, e);
        ex = sb.pop_front();
        n_cmp++; if (lat !== 3) begin n_bad++; $display("FAIL rd_latency: got %0d want 3", lat); end
        n_cmp++; if (rd !== ex.rdata) begin n_bad++; $display("FAIL rd_data: got %h want %h", rd, ex.rdata); end
        n_cmp++; if (e !== ex.err) begin n_bad++; $display("FAIL rd_err: got %b want %b", e, ex.err); end
        n_cmp++; if (bus.d_rdata !== exp_d_rd) begin n_bad++; $display("FAIL rd_d_untouched: got %h want %h", bus.d_rdata, exp_d_rd); end
        // A write elsewhere must leave the held read data alone.
        sb.push_back(predict(1'b0, 1'b1, 32'h14, 32'h0BAD_F00D));
        drive(1'b0, 1'b1, 32'h14, 32'h0BAD_F00D, 32'h108, lat, st, wes, rd, e);
        ex = sb.pop_front();
        repeat (3) @(posedge clk);
        #1;
        n_cmp++; if (bus.c_rdata !== ex.rdata) begin n_bad++; $display("FAIL rd_held: got %h want %h", bus.c_rdata, ex.rdata); end
    endtask

    task automatic test_tie();
        exp_t ex; int nack = 0; bit raise_c = 0, raise_d = 0; logic [31:0] rd;
        Reset = 1'b0; exp_c_rd = '0; exp_d_rd = '0;
        @(posedge clk); #1; Reset = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < 4; i++) sb.push_back(predict(i[0], 1'b0, 32'h10, 32'h0));
        bus.c_we = 0; bus.c_addr = 32'h10; bus.d_we = 0; bus.d_addr = 32'h10;
        bus.c_req = 1; bus.d_req = 1;
        for (int k = 1; k <= 40 && nack < 4; k++) begin
            @(negedge clk);
            if (bus.c_ack || bus.d_ack) begin
                ex = sb.pop_front();
                nack++;
                rd = bus.d_ack ? bus.d_rdata : bus.c_rdata;
                n_cmp++; if ((bus.c_ack && bus.d_ack) !== 1'b0) begin n_bad++; $display("FAIL tie_double_ack: ack %0d both ports", nack); end
                n_cmp++; if (bus.d_ack !== ex.port) begin n_bad++; $display("FAIL tie_winner: ack %0d got port %b want %b", nack, bus.d_ack, ex.port); end
                n_cmp++; if (k !== 3 * nack) begin n_bad++; $display("FAIL tie_cycle: ack %0d at %0d want %0d", nack, k, 3 * nack); end
                n_cmp++; if (rd !== ex.rdata) begin n_bad++; $display("FAIL tie_rdata: ack %0d got %h want %h", nack, rd, ex.rdata); end
                if (bus.c_ack) begin bus.c_req = 0; raise_c = (nack < 3); end
                if (bus.d_ack) begin bus.d_req = 0; raise_d = (nack < 3); end
            end
            @(posedge clk); #1;
            if (raise_c) begin bus.c_req = 1; raise_c = 0; end
            if (raise_d) begin bus.d_req = 1; raise_d = 0; end
        end
        n_cmp++; if (nack !== 4) begin n_bad++; $display("FAIL tie_ack_count: got %0d want 4", nack); end
        bus.c_req = 0; bus.d_req = 0;
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        logic [31:0] addrs [3];
        logic [31:0] datas [3];
        exp_t ex; int lat, st, wes; logic [31:0] rd; logic e;
        addrs = '{32'h0, 32'h20, 32'h190};
        datas = '{32'hCAFE_0000, 32'h0000_0055, 32'hA5A5_0001};
        for (int p = 0; p < 2; p++) begin
            for (int i = 0; i < 3; i++) begin
                sb.push_back(predict(1'b1, p == 0, addrs[i], datas[i]));
                drive(1'b1, p == 0, addrs[i], datas[i], 32'h0, lat, st, wes, rd, e);
                ex = sb.pop_front();
                n_cmp++; if (lat !== 3) begin n_bad++; $display("FAIL b2b_latency: op %0d/%0d got %0d want 3", p, i, lat); end
                n_cmp++; if (rd !== ex.rdata) begin n_bad++; $display("FAIL b2b_rdata: op %0d/%0d got %h want %h", p, i, rd, ex.rdata); end
                n_cmp++; if (st !== 0) begin n_bad++; $display("FAIL b2b_cpu_stall: op %0d/%0d got %0d want 0", p, i, st); end
            end
        end
    endtask

    task automatic test_invalid();
        logic [31:0] addrs [2];
        exp_t ex; int lat, st, wes; logic [31:0] rd; logic e;
        addrs = '{32'h0000_1002, 32'h0000_1000};
        for (int i = 0; i < 2; i++) begin
            sb.push_back(predict(1'b0, 1'b1, addrs[i], 32'h0000_BAD1));
            drive(1'b0, 1'b1, addrs[i], 32'h0000_BAD1, 32'h200, lat, st, wes, rd, e);
            ex = sb.pop_front();
            n_cmp++; if (wes !== 0) begin n_bad++; $display("FAIL inv_mem_we: addr %h got %0d cycles want 0", addrs[i], wes); end
            n_cmp++; if (e !== ex.err) begin n_bad++; $display("FAIL inv_err: addr %h got %b want %b", addrs[i], e, ex.err); end
            n_cmp++; if (lat !== 3) begin n_bad++; $display("FAIL inv_latency: addr %h got %0d want 3", addrs[i], lat); end
        end
        n_cmp++; if (mem[0] !== 32'hCAFE_0000) begin n_bad++; $display("FAIL inv_word0: got %h want cafe0000", mem[0]); end
        for (int i = 0; i < 2; i++) begin
            sb.push_back(predict(1'b0, 1'b0, i == 0 ? 32'h1000 : 32'h10, 32'h0));
            drive(1'b0, 1'b0, i == 0 ? 32'h1000 : 32'h10, 32'h0, 32'h204, lat, st, wes, rd, e);
            ex = sb.pop_front();
            n_cmp++; if (rd !== ex.rdata) begin n_bad++; $display("FAIL inv_read_data: case %0d got %h want %h", i, rd, ex.rdata); end
            n_cmp++; if (e !== ex.err) begin n_bad++; $display("FAIL inv_read_err: case %0d got %b want %b", i, e, ex.err); end
        end
    endtask

    task automatic test_reset_mid();
        exp_t ex; int lat, st, wes; logic [31:0] rd; logic e;
        bus.c_we = 1; bus.c_addr = 32'h20; bus.c_wdata = 32'hDEAD_BEEF; bus.c_req = 1;
        @(posedge clk); #2;
        n_cmp++; if (bus.mem_we !== 1'b1) begin n_bad++; $display("FAIL rstmid_in_access: mem_we %b want 1", bus.mem_we); end
        Reset = 1'b0;
        #1;
        n_cmp++; if ({bus.mem_we, bus.c_ack, bus.d_ack, bus.err} !== 4'b0) begin
            n_bad++; $display("FAIL rstmid_ctrl: got %b want 0000", {bus.mem_we, bus.c_ack, bus.d_ack, bus.err});
        end
        n_cmp++; if ({bus.c_rdata, bus.d_rdata, 22'(bus.mem_addr)} !== 86'h0) begin
            n_bad++; $display("FAIL rstmid_data: c_rdata %h d_rdata %h mem_addr %h want all 0", bus.c_rdata, bus.d_rdata, bus.mem_addr);
        end
        bus.c_req = 0;
        repeat (2) @(posedge clk);
        @(negedge clk); Reset = 1'b1; exp_c_rd = '0; exp_d_rd = '0;
        n_cmp++; if (mem[8] !== 32'h0000_0055) begin n_bad++; $display("FAIL rstmid_word8: got %h want 00000055", mem[8]); end
        @(posedge clk); #1;
        sb.push_back(predict(1'b0, 1'b0, 32'h20, 32'h0));
        drive(1'b0, 1'b0, 32'h20, 32'h0, 32'h300, lat, st, wes, rd, e);
        ex = sb.pop_front();
        n_cmp++; if (lat !== 3) begin n_bad++; $display("FAIL rstmid_next_latency: got %0d want 3", lat); end
        n_cmp++; if (rd !== ex.rdata) begin n_bad++; $display("FAIL rstmid_next_rdata: got %h want %h", rd, ex.rdata); end
    endtask

    task automatic test_trace_write();
        exp_t ex; int lat, st, wes; logic [31:0] rd; logic e;
        sb.push_back(predict(1'b0, 1'b1, 32'h4, 32'hA));
        drive(1'b0, 1'b1, 32'h4, 32'hA, 32'h0000_3000, lat, st, wes, rd, e);
        ex = sb.pop_front();
        n_cmp++; if (mem[1] !== 32'hA) begin n_bad++; $display("FAIL trace_word1: got %h want 0000000a", mem[1]); end
        n_cmp++; if (e !== ex.err) begin n_bad++; $display("FAIL trace_err: got %b want %b", e, ex.err); end
    endtask

    initial begin
        test_reset();
        test_cpu_write();
        test_cpu_read();
        test_tie();
        test_back_to_back();
        test_invalid();
        test_reset_mid();
        test_trace_write();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, %0d compared / %0d mismatched", n_cmp, n_bad);
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/dm_arbiter.md
Name: dm_arbiter

Overview:
Two-port access controller for the single-port word-addressed data memory (1024 x 32, combinational read, write on posedge clk).
Shares the memory between the CPU MEM-stage data port (port C) and a debug/loader port (port D).
- Req/ack handshake per port; round-robin on contention.
- Stall to the pipeline while the CPU access is pending.
- Address checking before any write reaches the memory.

Parameters:
ADDR_W, 10, word-address width driven to memory (2^ADDR_W words).
DATA_W, 32, data width.

Ports:
clk  in  1  system clock, all state on rising edge.
Reset  in  1  asynchronous, active-low reset (0 = reset asserted).
c_req  in  1  CPU access request; held until c_ack.
c_we  in  1  CPU write (1) / read (0).
c_addr  in  32  CPU byte address.
c_wdata  in  DATA_W  CPU write data.
c_pc  in  32  PC of the requesting instruction (trace only).
c_rdata  out  DATA_W  CPU read data.
c_ack  out  1  CPU access complete (one-cycle pulse).
c_stall  out  1  pipeline stall = c_req & ~c_ack.
d_req, d_we, d_addr[31:0], d_wdata[DATA_W]  in  debug port, same meaning as the CPU port.
d_rdata  out  DATA_W  debug read data.
d_ack  out  1  debug access complete.
mem_we  out  1  memory write enable.
mem_addr  out  ADDR_W  memory word address.
mem_wdata  out  DATA_W  memory write data.
mem_rdata  in  DATA_W  memory combinational read data.
err  out  1  one-cycle pulse with ack when the granted address is invalid.

Behaviour:
- FSM states:
  - IDLE: arbitrate. Any req -> latch winner's we/addr/wdata/port id -> ACCESS.
  - ACCESS: drive memory from latched regs.
  - DONE: ack pulse -> IDLE unconditionally. Req ignored in DONE.
- Latency: req seen in IDLE at cycle N -> ACCESS at N+1 -> ack=1 at N+2. Throughput one access per 3 cycles.
- Arbitration:
  - Only one req -> that port wins.
  - Both -> port != last_gnt wins. last_gnt updates on each grant.
  - last_gnt resets to D, so the CPU wins the first tie.
- ACCESS outputs:
  - mem_addr = latched addr[ADDR_W+1:2]; mem_wdata = latched data.
  - mem_we = latched we & valid. The write commits on the edge leaving ACCESS.
  - Read: mem_rdata is captured into the granted port's rdata register on the edge leaving ACCESS.
- Outside ACCESS: mem_we=0; mem_addr/mem_wdata hold the last latched values.
- rdata registers:
  - Valid from N+2; held until that port's next completed read.
  - Writes do not change rdata.
- valid = (addr[1:0]==0) && (addr[31:ADDR_W+2]==0).
  - Invalid: no write (mem_we stays 0), rdata register loads 0, err=1 in DONE alongside ack.
- Only the granted port sees ack. The other port's req stays pending and is served next.
- Requester must drop req in the cycle after ack. If req is still high when the FSM returns to IDLE, it is a new request.
- Reset asserted (any time, including mid-ACCESS):
  - Immediately: state=IDLE, mem_we=0, c_ack=d_ack=err=0.
  - c_rdata=d_rdata=0, last_gnt=D, latched regs=0.
  - An in-flight write is dropped. Memory contents are not touched by this block.
- Changes to req inputs during ACCESS/DONE have no effect on the current access.

Optional Feature:
DM_TRACE_EN defined:
- On every committed CPU-port write, simulation prints `$display("@%h: *%h <= %h", pc, addr, data)` using the latched c_pc, byte address and data.
- Debug-port writes print with pc = 32'hFFFFFFFF.
- Invalid writes print nothing.
DM_TRACE_EN undefined: no display statements, no latched pc register; behaviour otherwise identical.

Test Plan:
1. Reset low 2 cycles, release; CPU write addr=0x0000_0010 data=0x1234_5678 -> c_stall high 2 cycles, c_ack at N+2, word 4 = 0x12345678, err=0.
2. CPU read addr=0x10 after case 1 -> c_rdata=0x12345678 at N+2 and held; d_rdata stays 0.
3. c_req and d_req both asserted from IDLE after reset -> CPU granted first (ack N+2), D acked 3 cycles later; repeat tie -> alternates C, D, C.
4. CPU write addr=0x0000_1002 (misaligned) and addr=0x0000_1000 (out of range) -> mem_we never 1, err=1 with c_ack, c_rdata=0 on read variant.
5. Reset asserted during ACCESS of a write to 0x20 -> mem_we drops same cycle, word 8 unchanged, outputs at reset values, next request served normally.
6. With DM_TRACE_EN, CPU write pc=0x00003000 addr=0x4 data=0xA -> log line "@00003000: *00000004 <= 0000000a"; without macro, no output.
